// File: rtl/cpu_control_unit.sv
// Fetch/decode control for the 8-bit single-cycle processor.
// Holds the PC, decodes the 32-bit instruction into register-file addresses
// and ALU controls, sequences sequential/jump/beq flow, stalls on
// instruction-memory busy-wait, counts retired instructions and flags
// illegal opcodes.
//
// Handshake: INSTRUCTION is valid when IMEM_BUSYWAIT is low. In RUN, an
// instruction retires on each rising edge where it is valid. Retiring means
// the PC advances, RETIRED increments and the register file captures
// (WRITEENABLE). While IMEM_BUSYWAIT is high nothing is consumed and all
// architectural state holds.
module cpu_control_unit #(
    parameter logic [31:0] RESET_PC = 32'd0,
    parameter int          CNT_W    = 16
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [31:0]      INSTRUCTION,
    input  logic             IMEM_BUSYWAIT,
    input  logic             ZERO,
    output logic [31:0]      PC,
    output logic [2:0]       WRITEREG,
    output logic [2:0]       READREG1,
    output logic [2:0]       READREG2,
    output logic [7:0]       IMMEDIATE,
    output logic             WRITEENABLE,
    output logic [2:0]       ALUOP,
    output logic             IMM_SEL,
    output logic             NEG_SEL,
    output logic             ILLEGAL,
    output logic [CNT_W-1:0] RETIRED,
    output logic             dbg_state
);

    typedef enum logic {
        BOOT = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic [7:0]  opcode;
    logic        write_type;
    logic        illegal_op;
    logic        taken;
    logic        advance;
    logic [31:0] pc_seq;
    logic [31:0] pc_tgt;
    logic        unused_bits;

    // Field slices follow INSTRUCTION at all times.
    assign opcode      = INSTRUCTION[31:24];
    assign WRITEREG    = INSTRUCTION[18:16];
    assign READREG1    = INSTRUCTION[10:8];
    assign READREG2    = INSTRUCTION[2:0];
    assign IMMEDIATE   = INSTRUCTION[7:0];
    assign unused_bits = ^{INSTRUCTION[15:11], INSTRUCTION[7:3]};
    assign dbg_state   = state_q;

    // One instruction retires per RUN cycle with a valid instruction.
    assign advance     = (state_q == RUN) && !IMEM_BUSYWAIT;
    assign WRITEENABLE = advance && write_type;

    // Branch target is relative to PC+4, word offset sign-extended from 8 bits.
    assign pc_seq = PC + 32'd4;
    assign pc_tgt = pc_seq + {{22{INSTRUCTION[23]}}, INSTRUCTION[23:16], 2'b00};
    assign taken  = (opcode == 8'd6) || ((opcode == 8'd7) && ZERO);

    // Opcode decode into ALU controls; undefined opcodes drive everything low.
    always_comb begin
        ALUOP      = 3'd0;
        IMM_SEL    = 1'b0;
        NEG_SEL    = 1'b0;
        write_type = 1'b0;
        illegal_op = 1'b0;
        case (opcode)
            8'd0: begin ALUOP = 3'd0; IMM_SEL = 1'b1; write_type = 1'b1; end
            8'd1: begin ALUOP = 3'd0; write_type = 1'b1; end
            8'd2: begin ALUOP = 3'd1; write_type = 1'b1; end
            8'd3: begin ALUOP = 3'd1; NEG_SEL = 1'b1; write_type = 1'b1; end
            8'd4: begin ALUOP = 3'd2; write_type = 1'b1; end
            8'd5: begin ALUOP = 3'd3; write_type = 1'b1; end
            8'd6: begin ALUOP = 3'd0; end
            8'd7: begin ALUOP = 3'd1; NEG_SEL = 1'b1; end
            default: illegal_op = 1'b1;
        endcase
    end

    // BOOT covers the memory read latency of the first PC, then RUN forever.
    always_comb begin
        state_d = state_q;
        case (state_q)
            BOOT:    state_d = RUN;
            RUN:     state_d = RUN;
            default: state_d = BOOT;
        endcase
    end

    // State register; reset wins over any pending update.
    always_ff @(posedge CLK) begin
        if (!RESET) state_q <= BOOT;
        else        state_q <= state_d;
    end

    // PC, retirement counter and sticky illegal flag advance only on retire.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            PC      <= RESET_PC;
            RETIRED <= '0;
            ILLEGAL <= 1'b0;
        end else if (advance) begin
            PC      <= taken ? pc_tgt : pc_seq;
            RETIRED <= RETIRED + CNT_W'(1);
            if (illegal_op) ILLEGAL <= 1'b1;
        end
    end

endmodule

// File: tb/tb_cpu_control_unit.sv
// Self-checking bench for cpu_control_unit: directed scenarios plus random
// instruction streams, compared against a behavioural model of the PC,
// retirement count, illegal flag and decode table.
module tb_cpu_control_unit;

    localparam int CNT_W = 4;

    logic             CLK = 1'b0;
    logic             RESET = 1'b0;
    logic [31:0]      INSTRUCTION = 32'd0;
    logic             IMEM_BUSYWAIT = 1'b0;
    logic             ZERO = 1'b0;
    logic [31:0]      PC;
    logic [2:0]       WRITEREG, READREG1, READREG2, ALUOP;
    logic [7:0]       IMMEDIATE;
    logic             WRITEENABLE, IMM_SEL, NEG_SEL, ILLEGAL, dbg_state;
    logic [CNT_W-1:0] RETIRED;

    cpu_control_unit #(.RESET_PC(32'd0), .CNT_W(CNT_W)) dut (
        .CLK(CLK), .RESET(RESET), .INSTRUCTION(INSTRUCTION),
        .IMEM_BUSYWAIT(IMEM_BUSYWAIT), .ZERO(ZERO), .PC(PC),
        .WRITEREG(WRITEREG), .READREG1(READREG1), .READREG2(READREG2),
        .IMMEDIATE(IMMEDIATE), .WRITEENABLE(WRITEENABLE), .ALUOP(ALUOP),
        .IMM_SEL(IMM_SEL), .NEG_SEL(NEG_SEL), .ILLEGAL(ILLEGAL),
        .RETIRED(RETIRED), .dbg_state(dbg_state)
    );

    // Clock block
    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_pass   = 0;

    // Scoreboard: model state and expected PC after each edge.
    logic [31:0] exp_q[$];
    logic [31:0] m_pc;
    bit          m_run;
    bit          m_known = 1'b0;
    int          m_ret;
    bit          m_ill;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    // Decode table: {aluop, imm_sel, neg_sel, writes}
    function automatic logic [5:0] ref_decode(input logic [7:0] op);
        case (op)
            8'd0: return {3'd0, 1'b1, 1'b0, 1'b1};
            8'd1: return {3'd0, 1'b0, 1'b0, 1'b1};
            8'd2: return {3'd1, 1'b0, 1'b0, 1'b1};
            8'd3: return {3'd1, 1'b0, 1'b1, 1'b1};
            8'd4: return {3'd2, 1'b0, 1'b0, 1'b1};
            8'd5: return {3'd3, 1'b0, 1'b0, 1'b1};
            8'd6: return {3'd0, 1'b0, 1'b0, 1'b0};
            8'd7: return {3'd1, 1'b0, 1'b1, 1'b0};
            default: return 6'd0;
        endcase
    endfunction

    task automatic check_comb();
        logic [5:0] d;
        logic [7:0] op;
        op = INSTRUCTION[31:24];
        d  = ref_decode(op);
        check_eq("writereg", 32'(WRITEREG), 32'(INSTRUCTION[18:16]));
        check_eq("readreg1", 32'(READREG1), 32'(INSTRUCTION[10:8]));
        check_eq("readreg2", 32'(READREG2), 32'(INSTRUCTION[2:0]));
        check_eq("immediate", 32'(IMMEDIATE), 32'(INSTRUCTION[7:0]));
        check_eq("aluop", 32'(ALUOP), 32'(d[5:3]));
        check_eq("imm_sel", 32'(IMM_SEL), 32'(d[2]));
        check_eq("neg_sel", 32'(NEG_SEL), 32'(d[1]));
        if (m_known) begin
            check_eq("writeenable", 32'(WRITEENABLE), 32'(m_run && !IMEM_BUSYWAIT && d[0]));
            check_eq("pc", PC, m_pc);
            check_eq("retired", 32'(RETIRED), 32'(m_ret));
            check_eq("illegal", 32'(ILLEGAL), 32'(m_ill));
            check_eq("state", 32'(dbg_state), 32'(m_run));
        end
    endtask

    // Model of one rising edge, from the architectural rules.
    task automatic model_edge();
        logic [7:0] op;
        byte        off_b;
        int         off_i;
        op = INSTRUCTION[31:24];
        if (!RESET) begin
            m_pc = 32'd0; m_run = 1'b0; m_ret = 0; m_ill = 1'b0; m_known = 1'b1;
        end else if (m_known) begin
            if (!m_run) begin
                m_run = 1'b1;
            end else if (!IMEM_BUSYWAIT) begin
                m_ret = (m_ret + 1) % (1 << CNT_W);
                if (op > 8'd7) m_ill = 1'b1;
                off_b = INSTRUCTION[23:16];
                off_i = off_b;
                if (op == 8'd6 || (op == 8'd7 && ZERO)) m_pc = m_pc + 32'(4 + off_i * 4);
                else m_pc = m_pc + 32'd4;
            end
        end
        if (m_known) exp_q.push_back(m_pc);
    endtask

    // Driver: one clock cycle with the given inputs.
    task automatic step(input logic rst, input logic [31:0] instr, input logic busy, input logic zero);
        logic [31:0] e;
        @(negedge CLK);
        RESET = rst; INSTRUCTION = instr; IMEM_BUSYWAIT = busy; ZERO = zero;
        #1;
        check_comb();
        @(posedge CLK);
        model_edge();
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check_eq("pc_after_edge", PC, e);
        end
    endtask

    localparam logic [31:0] LOADI = 32'h0002005F;
    localparam logic [31:0] SUB   = 32'h03040102;
    localparam logic [31:0] ADD   = 32'h02030102;

    initial begin
        logic [31:0] r;
        logic [7:0]  op;
        int          k;

        // Reset release and first loadi
        step(1'b0, LOADI, 1'b0, 1'b0);
        step(1'b0, LOADI, 1'b0, 1'b0);
        step(1'b1, LOADI, 1'b0, 1'b0);      // BOOT edge
        check_eq("tp_boot_pc", PC, 32'd0);
        step(1'b1, LOADI, 1'b0, 1'b0);
        check_eq("tp_loadi_pc", PC, 32'd4);
        check_eq("tp_loadi_ret", 32'(RETIRED), 32'd1);

        // Sub decode, then jump/beq flow starting from PC=8
        step(1'b1, SUB, 1'b0, 1'b0);
        check_eq("tp_sub_pc", PC, 32'd8);
        step(1'b1, 32'h06FE0000, 1'b0, 1'b0);
        check_eq("tp_j_back", PC, 32'd4);
        step(1'b1, 32'h07030000, 1'b0, 1'b1);
        check_eq("tp_beq_taken", PC, 32'd20);
        step(1'b1, 32'h06FB0000, 1'b0, 1'b0);
        check_eq("tp_j_to4", PC, 32'd4);
        step(1'b1, 32'h07030000, 1'b0, 1'b0);
        check_eq("tp_beq_not", PC, 32'd8);
        step(1'b1, 32'h06FF0000, 1'b0, 1'b0);
        check_eq("tp_j_self", PC, 32'd8);

        // Busy-wait stall during add (ZERO toggling is ignored)
        for (int i = 0; i < 3; i++) step(1'b1, ADD, 1'b1, i[0]);
        check_eq("tp_stall_pc", PC, 32'd8);
        step(1'b1, ADD, 1'b0, 1'b0);
        check_eq("tp_release_pc", PC, 32'd12);

        // Illegal opcode is sticky across legal instructions
        step(1'b1, 32'hAB000000, 1'b0, 1'b0);
        check_eq("tp_illegal", 32'(ILLEGAL), 32'd1);
        step(1'b1, ADD, 1'b0, 1'b0);
        step(1'b1, LOADI, 1'b0, 1'b0);
        check_eq("tp_illegal_sticky", 32'(ILLEGAL), 32'd1);

        // Mid-run reset during busy-wait at PC=0x40, then counter wrap
        step(1'b0, LOADI, 1'b0, 1'b0);
        check_eq("tp_illegal_clr", 32'(ILLEGAL), 32'd0);
        step(1'b1, LOADI, 1'b0, 1'b0);
        step(1'b1, 32'h060F0000, 1'b0, 1'b0);
        check_eq("tp_pc_40", PC, 32'h40);
        step(1'b0, ADD, 1'b1, 1'b0);
        check_eq("tp_midrst_pc", PC, 32'd0);
        step(1'b1, LOADI, 1'b0, 1'b0);
        for (int i = 0; i < 16; i++) step(1'b1, LOADI, 1'b0, 1'b0);
        check_eq("tp_wrap_ret", 32'(RETIRED), 32'd0);
        check_eq("tp_wrap_pc", PC, 32'd64);

        // Random instruction streams
        for (int i = 0; i < 400; i++) begin
            r = $urandom();
            k = $urandom_range(0, 9);
            op = (k <= 7) ? 8'(k) : 8'($urandom_range(8, 255));
            step($urandom_range(0, 49) != 0, {op, r[23:0]},
                 $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
